// File: rtl/imem_loader.sv
// imem_loader: receives a program image as a byte stream, assembles 32-bit
// little-endian words and writes them into instruction memory. The core is
// held stalled (CORE_RUN low) until a full image with a matching XOR
// checksum has been loaded.
//
// Stream: count lo, count hi, 4*N data bytes, checksum (XOR of data bytes).
//
// Optional build macro LOADER_TIMEOUT_EN: when defined, a loading session
// that sees no accepted byte for TIMEOUT_CYCLES cycles drops into ERROR.
module imem_loader #(
  parameter int ADDR_W         = 10,
  parameter int BASE_ADDR      = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              RX_VALID,
  input  logic [7:0]        RX_DATA,
  output logic              RX_READY,
  output logic              WE,
  output logic [ADDR_W-1:0] WA,
  output logic [31:0]       WD,
  output logic              CORE_RUN,
  output logic              BUSY,
  output logic              ERR
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_CNT_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // Largest legal word count; the count field is 16 bits so compare in 32.
  localparam int unsigned CAP = 32'd1 << ADDR_W;

  logic [2:0]  state;
  logic [15:0] cnt;        // word count N of the current image
  logic [15:0] word_idx;   // words completed so far
  logic [1:0]  byte_idx;   // byte position within the current word
  logic [23:0] asm_word;   // first three bytes of the word being assembled
  logic [7:0]  csum;       // running XOR of data bytes
  logic [15:0] n_full;     // count as it will be once the high byte lands
  logic        accept;
  logic        timeout;

  // Status outputs are pure decodes of the registered state.
  assign BUSY     = (state == S_CNT_LO) || (state == S_CNT_HI) ||
                    (state == S_DATA)   || (state == S_CHK);
  assign RX_READY = BUSY;
  assign CORE_RUN = (state == S_DONE);
  assign ERR      = (state == S_ERROR);

  assign accept = RX_VALID && RX_READY;
  assign n_full = {RX_DATA, cnt[7:0]};

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  // Idle-gap counter: cleared by any accepted byte, START or leaving busy.
  always_ff @(posedge CLK) begin
    if (!RST || START || accept || !BUSY) tcnt <= '0;
    else                                  tcnt <= tcnt + 1'b1;
  end

  assign timeout = BUSY && !accept && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Main loader FSM with registered memory write port.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      csum     <= '0;
      WE       <= 1'b0;
      WA       <= '0;
      WD       <= '0;
    end else begin
      WE <= 1'b0;
      if (START) begin
        // START wins over everything, including a coinciding byte.
        state    <= S_CNT_LO;
        cnt      <= '0;
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end else if (timeout) begin
        state <= S_ERROR;
      end else if (accept) begin
        case (state)
          S_CNT_LO: begin
            cnt[7:0] <= RX_DATA;
            state    <= S_CNT_HI;
          end
          S_CNT_HI: begin
            cnt[15:8] <= RX_DATA;
            if (32'(n_full) > CAP)  state <= S_ERROR;
            else if (n_full == '0) state <= S_CHK;
            else                   state <= S_DATA;
          end
          S_DATA: begin
            csum     <= csum ^ RX_DATA;
            byte_idx <= byte_idx + 2'd1;
            asm_word <= {RX_DATA, asm_word[23:8]};
            if (byte_idx == 2'd3) begin
              // Word complete: write lands the cycle after the 4th byte.
              WE       <= 1'b1;
              WA       <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);
              WD       <= {RX_DATA, asm_word};
              word_idx <= word_idx + 16'd1;
              // Moving to CHK now lets the checksum byte follow without a bubble.
              if (word_idx == cnt - 16'd1) state <= S_CHK;
            end
          end
          S_CHK: begin
            state <= (RX_DATA == csum) ? S_DONE : S_ERROR;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams against a
// stream-position reference model, plus literal checks on known images.
module tb_imem_loader;
  localparam int AW   = 10;
  localparam int CAP  = 1 << AW;
  localparam int BASE = 0;
  localparam int TO   = 50;

  logic          CLK = 1'b0;
  logic          RST, START, RX_VALID;
  logic [7:0]    RX_DATA;
  logic          RX_READY, WE, CORE_RUN, BUSY, ERR;
  logic [AW-1:0] WA;
  logic [31:0]   WD;

  int tests = 0;
  int fails = 0;

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .START(START), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .RX_READY(RX_READY), .WE(WE), .WA(WA), .WD(WD),
    .CORE_RUN(CORE_RUN), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: tracks position in the byte stream of the current load.
  bit            m_started = 0;
  bit            m_load = 0;     // a load session is open (bytes accepted)
  int            m_stat = 0;     // 0 none, 1 passed, 2 failed
  int            m_pos = 0, m_n = 0, m_stall = 0;
  logic [7:0]    m_csum = 0;
  logic [31:0]   m_asm = 0;
  logic          m_we = 0;
  logic [AW-1:0] m_wa = 0;
  logic [31:0]   m_wd = 0;

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (m_pos == 0) begin
      m_n = int'(b);
    end else if (m_pos == 1) begin
      m_n = m_n + 256 * int'(b);
      if (m_n > CAP) begin m_load = 0; m_stat = 2; end
    end else if (m_pos < 2 + 4 * m_n) begin
      k = m_pos - 2;
      m_asm[(k % 4) * 8 +: 8] = b;
      m_csum = m_csum ^ b;
      if (k % 4 == 3) begin
        m_we = 1;
        m_wa = AW'((BASE + k / 4) % CAP);
        m_wd = m_asm;
      end
    end else begin
      m_load = 0;
      m_stat = (b == m_csum) ? 1 : 2;
    end
    m_pos++;
  endtask

  always @(posedge CLK) begin
    if (!RST) begin
      m_load = 0; m_stat = 0; m_pos = 0; m_n = 0; m_stall = 0;
      m_csum = 0; m_we = 0; m_wa = 0; m_wd = 0;
    end else begin
      m_we = 0;
      if (START) begin
        m_load = 1; m_stat = 0; m_pos = 0; m_n = 0; m_csum = 0; m_stall = 0;
      end else if (m_load && RX_VALID) begin
        m_stall = 0;
        model_byte(RX_DATA);
      end else if (m_load) begin
`ifdef LOADER_TIMEOUT_EN
        if (m_stall == TO - 1) begin m_load = 0; m_stat = 2; end
        else m_stall++;
`endif
      end
    end
    m_started = 1;
  end

  // Per-cycle compare against the model, and a log of observed writes.
  logic [AW-1:0] log_wa[$];
  logic [31:0]   log_wd[$];

  always @(negedge CLK) begin
    if (m_started) begin
      tests++;
      if ({RX_READY, BUSY, CORE_RUN, ERR, WE} !== {m_load, m_load, m_stat == 1, m_stat == 2, m_we} ||
          WA !== m_wa || WD !== m_wd) begin
        fails++;
        $display("FAIL cycle t=%0t rdy/busy/run/err/we got %b%b%b%b%b wa=%0h wd=%h expected %b%b%b%b%b wa=%0h wd=%h",
                 $time, RX_READY, BUSY, CORE_RUN, ERR, WE, WA, WD,
                 m_load, m_load, m_stat == 1, m_stat == 2, m_we, m_wa, m_wd);
      end
      if (WE === 1'b1) begin log_wa.push_back(WA); log_wd.push_back(WD); end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    RX_VALID = 0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic pulse_start();
    START = 1;
    @(posedge CLK); #1;
    START = 0;
  endtask

  // Offer one byte, optionally after random gaps; waits (bounded) for accept.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    if (gaps && $urandom_range(0, 2) == 0) begin
      RX_VALID = 0;
      repeat ($urandom_range(1, 3)) begin RX_DATA = 8'($urandom); @(posedge CLK); #1; end
    end
    RX_VALID = 1; RX_DATA = b; ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge CLK);
      ok = (RX_READY === 1'b1);
      @(posedge CLK); #1;
    end
    RX_VALID = 0;
    if (!ok) begin
      fails++; tests++;
      $display("FAIL accept_wait: byte %h not accepted within 20 cycles", b);
    end
  endtask

  logic [31:0] img[$];
  logic [7:0]  strm[$];

  // Builds count + image words + checksum; bad flips the checksum.
  task automatic make_stream(input bit bad);
    logic [7:0]  cs;
    logic [15:0] n;
    n = 16'(img.size());
    cs = 0;
    strm = {};
    strm.push_back(n[7:0]);
    strm.push_back(n[15:8]);
    foreach (img[i]) begin
      for (int j = 0; j < 4; j++) begin
        strm.push_back(img[i][j*8 +: 8]);
        cs = cs ^ img[i][j*8 +: 8];
      end
    end
    strm.push_back(bad ? ~cs : cs);
  endtask

  task automatic load(input bit gaps);
    log_wa = {}; log_wd = {};
    pulse_start();
    foreach (strm[i]) send_byte(strm[i], gaps);
    idle(2);
  endtask

  task automatic check_image(input string nm, input bit good);
    chk({nm, "_nwrites"}, 64'(log_wa.size()), 64'(img.size()));
    for (int i = 0; i < img.size() && i < log_wa.size(); i++) begin
      chk({nm, "_wa"}, 64'(log_wa[i]), 64'((BASE + i) % CAP));
      chk({nm, "_wd"}, 64'(log_wd[i]), 64'(img[i]));
    end
    chk({nm, "_run"}, 64'(CORE_RUN), 64'(good));
    chk({nm, "_err"}, 64'(ERR), 64'(!good));
  endtask

  initial begin
    bit good;
    int n;
    RST = 0; START = 0; RX_VALID = 0; RX_DATA = 0;
    repeat (2) begin @(posedge CLK); #1; end
    chk("reset_outs", {RX_READY, WE, CORE_RUN, BUSY, ERR}, 5'b0);
    chk("reset_wa_wd", {WA, WD}, '0);
    RST = 1;
    idle(2);

    // Basic two-word image; checksum 13^93^10 = 0x90.
    strm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    load(0);
    chk("basic_nwrites", 64'(log_wa.size()), 2);
    chk("basic_w0", {log_wa[0], log_wd[0]}, {10'd0, 32'h0000_0013});
    chk("basic_w1", {log_wa[1], log_wd[1]}, {10'd1, 32'h0010_0093});
    chk("basic_done", {CORE_RUN, ERR, BUSY}, 3'b100);

    // Same image with checksums 0x00 and 0x93 (both wrong) -> ERROR.
    strm[10] = 8'h00;
    load(0);
    chk("badcs_state", {CORE_RUN, ERR}, 2'b01);
    strm[10] = 8'h93;
    load(0);
    chk("badcs93_state", {CORE_RUN, ERR}, 2'b01);
    strm[10] = 8'h90;
    load(0);
    chk("recover_done", {CORE_RUN, ERR}, 2'b10);

    // Oversize count 1025 -> ERROR right after the second count byte.
    log_wa = {};
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    chk("oversize_err", {ERR, BUSY, RX_READY}, 3'b100);
    idle(3);
    chk("oversize_nowrite", 64'(log_wa.size()), 0);

    // Zero count: only a zero checksum follows.
    strm = '{8'h00, 8'h00, 8'h00};
    load(0);
    chk("zero_nowrite", 64'(log_wa.size()), 0);
    chk("zero_done", {CORE_RUN, ERR}, 2'b10);

    // Four-word image with random gaps.
    img = {};
    for (int i = 0; i < 4; i++) img.push_back($urandom);
    make_stream(0);
    load(1);
    check_image("gaps4", 1);

    // Random images, random sizes, mostly good checksums.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 7);
      good = ($urandom_range(0, 3) != 0);
      img = {};
      for (int i = 0; i < n; i++) img.push_back($urandom);
      make_stream(!good);
      load(r[0]);
      check_image("rand", good);
    end

    // Full-capacity image, back-to-back bytes.
    img = {};
    for (int i = 0; i < CAP; i++) img.push_back($urandom);
    make_stream(0);
    load(0);
    chk("full_nwrites", 64'(log_wa.size()), 64'(CAP));
    chk("full_last_wa", 64'(log_wa[CAP-1]), 64'(CAP - 1));
    chk("full_run", {CORE_RUN, ERR}, 2'b10);

    // START mid-load restarts with a fresh count and checksum.
    log_wa = {};
    pulse_start();
    strm = '{8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    foreach (strm[i]) send_byte(strm[i], 0);
    img = '{32'hDEAD_BEEF};
    make_stream(0);
    load(0);
    check_image("restart", 1);

    // Reset after word 1 has been written.
    img = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    make_stream(0);
    log_wa = {};
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(strm[i], 0);
    idle(2);
    chk("midrst_writes", 64'(log_wa.size()), 2);
    RST = 0;
    @(posedge CLK); #1;
    chk("midrst_outs", {RX_READY, WE, CORE_RUN, BUSY, ERR}, 5'b0);
    chk("midrst_wa_wd", {WA, WD}, '0);
    RST = 1;
    idle(2);

`ifdef LOADER_TIMEOUT_EN
    // Stall in DATA for longer than the timeout.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h55, 0);
    idle(TO + 2);
    chk("timeout_err", {ERR, BUSY}, 2'b10);
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
